// File: rtl/spike_queue_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spike_queue_scheduler_if : bundle between the router's Aux/Out event FIFOs,
// the spike queue scheduler and the synaptic-integration stage.
// Revision : 1.0
// ============================================================================
interface spike_queue_scheduler_if #(
  parameter int NEURON_WIDTH = 11,
  parameter int BT_WIDTH     = 36,
  parameter int COUNT_WIDTH  = 16
);
  logic                    schedule_enable;
  logic [BT_WIDTH-1:0]     current_bt;

  logic                    aux_is_queue_empty;
  logic [BT_WIDTH-1:0]     aux_bt_head;
  logic [BT_WIDTH-1:0]     aux_bt_out;
  logic [NEURON_WIDTH-1:0] aux_nid_out;
  logic                    aux_dequeue;

  logic                    out_is_queue_empty;
  logic [BT_WIDTH-1:0]     out_bt_head;
  logic [BT_WIDTH-1:0]     out_bt_out;
  logic [NEURON_WIDTH-1:0] out_nid_out;
  logic                    out_dequeue;

  logic                    event_valid;
  logic                    event_ready;
  logic [BT_WIDTH-1:0]     event_bt;
  logic [NEURON_WIDTH-1:0] event_nid;
  logic                    event_source;
  logic [COUNT_WIDTH-1:0]  event_count;
  logic                    schedule_complete;

  modport master (
    input  schedule_enable, current_bt,
           aux_is_queue_empty, aux_bt_head, aux_bt_out, aux_nid_out,
           out_is_queue_empty, out_bt_head, out_bt_out, out_nid_out,
           event_ready,
    output aux_dequeue, out_dequeue, event_valid, event_bt, event_nid,
           event_source, event_count, schedule_complete
  );

  modport slave (
    output schedule_enable, current_bt,
           aux_is_queue_empty, aux_bt_head, aux_bt_out, aux_nid_out,
           out_is_queue_empty, out_bt_head, out_bt_out, out_nid_out,
           event_ready,
    input  aux_dequeue, out_dequeue, event_valid, event_bt, event_nid,
           event_source, event_count, schedule_complete
  );
endinterface
`default_nettype wire

// File: rtl/spike_queue_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// spike_queue_scheduler : per-timestep drain of due spike events from the Aux
// and Out queues, merged in BT order, one event per valid/ready handshake.
// Revision : 1.0
// ============================================================================
module spike_queue_scheduler #(
  parameter int NEURON_WIDTH = 11,
  parameter int BT_WIDTH     = 36,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  spike_queue_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CHECK   = 3'd1;
  localparam logic [2:0] S_POP     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OFFER   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_WAIT    = 3'd6;

  logic [2:0]              r_state;
  logic                    r_sel;      // 0 = Aux, 1 = Out
  logic                    r_tie_pri;
  logic                    r_aux_dequeue;
  logic                    r_out_dequeue;
  logic                    r_event_valid;
  logic [BT_WIDTH-1:0]     r_event_bt;
  logic [NEURON_WIDTH-1:0] r_event_nid;
  logic                    r_event_source;
  logic [COUNT_WIDTH-1:0]  r_event_count;
  logic                    r_schedule_complete;

  logic w_aux_elig;
  logic w_out_elig;
  logic w_tie;
  logic w_pick_out;

  assign w_aux_elig = !bus.aux_is_queue_empty && (bus.aux_bt_head <= bus.current_bt);
  assign w_out_elig = !bus.out_is_queue_empty && (bus.out_bt_head <= bus.current_bt);
  assign w_tie      = w_aux_elig && w_out_elig && (bus.aux_bt_head == bus.out_bt_head);

  // Both due: earliest BT wins, ties go to the round-robin pointer.
  always_comb begin
    w_pick_out = w_out_elig;
    if (w_aux_elig && w_out_elig) begin
      if (w_tie) begin
        w_pick_out = r_tie_pri;
      end else begin
        w_pick_out = (bus.out_bt_head < bus.aux_bt_head);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state             <= S_IDLE;
      r_sel               <= 1'b0;
      r_tie_pri           <= 1'b0;
      r_aux_dequeue       <= 1'b0;
      r_out_dequeue       <= 1'b0;
      r_event_valid       <= 1'b0;
      r_event_bt          <= '0;
      r_event_nid         <= '0;
      r_event_source      <= 1'b0;
      r_event_count       <= '0;
      r_schedule_complete <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.schedule_enable) begin
            r_event_count <= '0;
            r_state       <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!bus.schedule_enable) begin
            r_state <= S_IDLE;
          end else if (w_aux_elig || w_out_elig) begin
            r_sel         <= w_pick_out;
            r_aux_dequeue <= !w_pick_out;
            r_out_dequeue <= w_pick_out;
            if (w_tie) begin
              r_tie_pri <= !r_tie_pri;
            end
            r_state <= S_POP;
          end else begin
            r_schedule_complete <= 1'b1;
            r_state             <= S_DONE;
          end
        end
        S_POP: begin
          r_aux_dequeue <= 1'b0;
          r_out_dequeue <= 1'b0;
          r_state       <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_event_bt     <= r_sel ? bus.out_bt_out  : bus.aux_bt_out;
          r_event_nid    <= r_sel ? bus.out_nid_out : bus.aux_nid_out;
          r_event_source <= r_sel;
          r_event_valid  <= 1'b1;
          r_state        <= S_OFFER;
        end
        S_OFFER: begin
          if (bus.event_ready) begin
            r_event_valid <= 1'b0;
            if (r_event_count != {COUNT_WIDTH{1'b1}}) begin
              r_event_count <= r_event_count + 1'b1;
            end
            r_state <= S_CHECK;
          end
        end
        S_DONE: begin
          r_schedule_complete <= 1'b0;
          r_state             <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.schedule_enable) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.aux_dequeue       = r_aux_dequeue;
  assign bus.out_dequeue       = r_out_dequeue;
  assign bus.event_valid       = r_event_valid;
  assign bus.event_bt          = r_event_bt;
  assign bus.event_nid         = r_event_nid;
  assign bus.event_source      = r_event_source;
  assign bus.event_count       = r_event_count;
  assign bus.schedule_complete = r_schedule_complete;

endmodule
`default_nettype wire

// File: tb/tb_spike_queue_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_spike_queue_scheduler : directed + randomized bench with FIFO models and
// a queue-level reference of the due-event merge order.
// Revision : 1.0
// ============================================================================
module tb_spike_queue_scheduler;
  localparam int NW = 11;
  localparam int BW = 36;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_queue_scheduler_if #(.NEURON_WIDTH(NW), .BT_WIDTH(BW), .COUNT_WIDTH(CW)) bus ();
  spike_queue_scheduler #(.NEURON_WIDTH(NW), .BT_WIDTH(BW), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO models: circular storage, read pointer owned by the pop process
  logic [BW-1:0] aux_bt_mem [256];
  logic [NW-1:0] aux_nid_mem[256];
  logic [BW-1:0] out_bt_mem [256];
  logic [NW-1:0] out_nid_mem[256];
  int aux_wr = 0, aux_rd = 0, out_wr = 0, out_rd = 0;

  assign bus.aux_is_queue_empty = (aux_rd == aux_wr);
  assign bus.aux_bt_head        = aux_bt_mem[aux_rd % 256];
  assign bus.out_is_queue_empty = (out_rd == out_wr);
  assign bus.out_bt_head        = out_bt_mem[out_rd % 256];

  always @(posedge clk) begin
    if (bus.aux_dequeue && aux_rd != aux_wr) begin
      bus.aux_bt_out  <= aux_bt_mem[aux_rd % 256];
      bus.aux_nid_out <= aux_nid_mem[aux_rd % 256];
      aux_rd          <= aux_rd + 1;
    end
    if (bus.out_dequeue && out_rd != out_wr) begin
      bus.out_bt_out  <= out_bt_mem[out_rd % 256];
      bus.out_nid_out <= out_nid_mem[out_rd % 256];
      out_rd          <= out_rd + 1;
    end
  end

  bit rand_ready  = 1'b0;
  bit ready_force = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.event_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Monitor (negedge): handshakes, strobes, protocol violations
  logic [BW-1:0] got_bt[$];
  logic [NW-1:0] got_nid[$];
  bit            got_src[$];
  int n_aux_deq = 0, n_out_deq = 0, n_complete = 0, n_deq_empty = 0, n_deq_both = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.event_valid && bus.event_ready) begin
        got_bt.push_back(bus.event_bt);
        got_nid.push_back(bus.event_nid);
        got_src.push_back(bus.event_source);
      end
      if (bus.aux_dequeue) n_aux_deq++;
      if (bus.out_dequeue) n_out_deq++;
      if (bus.aux_dequeue && bus.aux_is_queue_empty) n_deq_empty++;
      if (bus.out_dequeue && bus.out_is_queue_empty) n_deq_empty++;
      if (bus.aux_dequeue && bus.out_dequeue) n_deq_both++;
      if (bus.schedule_complete) n_complete++;
    end
  end

  // Reference model: queue contents and the tie pointer
  logic [BW-1:0] m_aux_bt[$], m_out_bt[$];
  logic [NW-1:0] m_aux_nid[$], m_out_nid[$];
  bit            m_tie = 1'b0;
  logic [BW-1:0] exp_bt[$];
  logic [NW-1:0] exp_nid[$];
  bit            exp_src[$];

  task automatic model_drain(input logic [BW-1:0] cur, input int limit, input bit commit);
    logic [BW-1:0] ab[$], ob[$];
    logic [NW-1:0] an[$], onn[$];
    bit tp;
    bit ae, oe, take_out;
    int n;
    ab = m_aux_bt; an = m_aux_nid; ob = m_out_bt; onn = m_out_nid; tp = m_tie; n = 0;
    exp_bt.delete(); exp_nid.delete(); exp_src.delete();
    while (n < limit) begin
      ae = (ab.size() > 0) && (ab[0] <= cur);
      oe = (ob.size() > 0) && (ob[0] <= cur);
      if (!ae && !oe) break;
      if (ae && oe && ab[0] == ob[0]) begin
        take_out = tp;
        tp = !tp;
      end else if (ae && oe) begin
        take_out = (ob[0] < ab[0]);
      end else begin
        take_out = oe;
      end
      if (take_out) begin
        exp_bt.push_back(ob.pop_front()); exp_nid.push_back(onn.pop_front()); exp_src.push_back(1'b1);
      end else begin
        exp_bt.push_back(ab.pop_front()); exp_nid.push_back(an.pop_front()); exp_src.push_back(1'b0);
      end
      n++;
    end
    if (commit) begin
      m_aux_bt = ab; m_aux_nid = an; m_out_bt = ob; m_out_nid = onn; m_tie = tp;
    end
  endtask

  task automatic push_ev(input bit to_out, input logic [BW-1:0] bt, input logic [NW-1:0] nid);
    if (to_out) begin
      out_bt_mem[out_wr % 256] = bt; out_nid_mem[out_wr % 256] = nid; out_wr++;
      m_out_bt.push_back(bt); m_out_nid.push_back(nid);
    end else begin
      aux_bt_mem[aux_wr % 256] = bt; aux_nid_mem[aux_wr % 256] = nid; aux_wr++;
      m_aux_bt.push_back(bt); m_aux_nid.push_back(nid);
    end
  endtask

  logic [BW-1:0] cur_r;
  int got_base, aux_base, out_base, cmp_base;

  task automatic start_round(input logic [BW-1:0] cur);
    cur_r = cur;
    model_drain(cur, 1000, 1'b0);
    got_base = got_bt.size(); aux_base = n_aux_deq; out_base = n_out_deq; cmp_base = n_complete;
    bus.current_bt      = cur;
    bus.schedule_enable = 1'b1;
  endtask

  task automatic wait_complete(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.schedule_complete && lat < 2000);
    check_eq("complete_seen", bus.schedule_complete, 1);
  endtask

  task automatic check_round(input string tag, input int exp_complete);
    int n, na;
    n  = got_bt.size() - got_base;
    na = 0;
    check_eq({tag, "_events"}, n, exp_bt.size());
    for (int i = 0; i < exp_bt.size() && i < n; i++) begin
      check_eq($sformatf("%s_bt%0d", tag, i),  got_bt[got_base + i],  exp_bt[i]);
      check_eq($sformatf("%s_nid%0d", tag, i), got_nid[got_base + i], exp_nid[i]);
      check_eq($sformatf("%s_src%0d", tag, i), got_src[got_base + i], exp_src[i]);
    end
    foreach (exp_src[i]) if (!exp_src[i]) na++;
    check_eq({tag, "_count"},     bus.event_count, exp_bt.size());
    check_eq({tag, "_aux_deq"},   n_aux_deq - aux_base, na);
    check_eq({tag, "_out_deq"},   n_out_deq - out_base, exp_bt.size() - na);
    check_eq({tag, "_complete"},  n_complete - cmp_base, exp_complete);
    check_eq({tag, "_deq_empty"}, n_deq_empty, 0);
    check_eq({tag, "_deq_both"},  n_deq_both, 0);
  endtask

  task automatic finish_round(input string tag, output int lat);
    wait_complete(lat);
    @(posedge clk); #1;
    bus.schedule_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_drain(cur_r, 1000, 1'b1);
    check_round(tag, 1);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.event_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("valid_seen", bus.event_valid, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_aux_deq"},  bus.aux_dequeue, 0);
    check_eq({tag, "_out_deq"},  bus.out_dequeue, 0);
    check_eq({tag, "_valid"},    bus.event_valid, 0);
    check_eq({tag, "_bt"},       bus.event_bt, 0);
    check_eq({tag, "_nid"},      bus.event_nid, 0);
    check_eq({tag, "_src"},      bus.event_source, 0);
    check_eq({tag, "_count"},    bus.event_count, 0);
    check_eq({tag, "_complete"}, bus.schedule_complete, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, deq_base;
    logic [BW-1:0] cur;
    bus.schedule_enable = 1'b0;
    bus.current_bt      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Two due Aux events in order
    push_ev(1'b0, 36'h40, 11'd8);
    push_ev(1'b0, 36'h50, 11'd20);
    start_round({32'd5, 4'h0});
    finish_round("basic", lat);
    check_eq("basic_nid_first",  got_nid[got_base],     11'd8);
    check_eq("basic_nid_second", got_nid[got_base + 1], 11'd20);

    // Interleave by BT
    push_ev(1'b0, 36'h30, 11'd1); push_ev(1'b0, 36'h48, 11'd2);
    push_ev(1'b1, 36'h38, 11'd3); push_ev(1'b1, 36'h50, 11'd4);
    start_round(36'h50);
    finish_round("interleave", lat);

    // Equal BT round-robin
    push_ev(1'b0, 36'h50, 11'd5); push_ev(1'b0, 36'h50, 11'd6);
    push_ev(1'b1, 36'h50, 11'd7); push_ev(1'b1, 36'h50, 11'd9);
    start_round(36'h50);
    finish_round("tie", lat);

    // Future-dated head stays put
    push_ev(1'b0, 36'h58, 11'd10);
    start_round(36'h50);
    finish_round("future", lat);
    check_eq("future_latency", lat, 3);

    // Backpressure: ready low for 10 cycles
    ready_force = 1'b0;
    @(posedge clk); #1;
    start_round(36'h60);
    wait_valid();
    deq_base = n_aux_deq + n_out_deq - aux_base - out_base;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp_valid%0d", i), bus.event_valid, 1);
      check_eq($sformatf("bp_bt%0d", i),    bus.event_bt, exp_bt[0]);
      check_eq($sformatf("bp_nid%0d", i),   bus.event_nid, exp_nid[0]);
    end
    check_eq("bp_no_extra_deq", n_aux_deq + n_out_deq - aux_base - out_base, deq_base);
    ready_force = 1'b1;
    finish_round("backpressure", lat);

    // Abort: enable drops while the event is offered
    push_ev(1'b0, 36'h62, 11'd11);
    push_ev(1'b0, 36'h63, 11'd12);
    ready_force = 1'b0;
    @(posedge clk); #1;
    start_round(36'h70);
    wait_valid();
    @(posedge clk); #1;
    bus.schedule_enable = 1'b0;
    repeat (3) @(posedge clk);
    ready_force = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    model_drain(cur_r, 1, 1'b1);
    check_round("abort", 0);
    check_eq("abort_valid_low", bus.event_valid, 0);

    // Randomized rounds
    rand_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      cur = 36'h100 + 36'(r) * 36'h20;
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 1) != 0)
          push_ev(k[0], cur - 36'h20 + 36'(8 * $urandom_range(0, 6)), NW'($urandom));
      end
      start_round(cur);
      finish_round($sformatf("rand%0d", r), lat);
    end
    rand_ready  = 1'b0;
    ready_force = 1'b1;

    // Reset during POP
    push_ev(1'b0, 36'h300, 11'd13);
    push_ev(1'b0, 36'h301, 11'd14);
    @(posedge clk); #1;
    start_round(36'h400);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.aux_dequeue || bus.out_dequeue) && lat < 200);
    check_eq("rst_pop_seen", bus.aux_dequeue | bus.out_dequeue, 1);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk); #1;
    bus.schedule_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("post_rst");
    m_aux_bt.delete(); m_aux_nid.delete(); m_out_bt.delete(); m_out_nid.delete();
    for (int i = aux_rd; i < aux_wr; i++) begin
      m_aux_bt.push_back(aux_bt_mem[i % 256]); m_aux_nid.push_back(aux_nid_mem[i % 256]);
    end
    for (int i = out_rd; i < out_wr; i++) begin
      m_out_bt.push_back(out_bt_mem[i % 256]); m_out_nid.push_back(out_nid_mem[i % 256]);
    end
    m_tie = 1'b0;
    start_round(36'h400);
    finish_round("after_rst", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spike_queue_scheduler.md
Name: spike_queue_scheduler

Overview:
- Per-timestep dispatcher sitting between the internal router's two event FIFOs (Aux queue and Out/external queue, both InputFIFO instances) and the downstream synaptic-integration stage.
- On each scheduling request it pops, one at a time, every queued spike event whose biological time (BT) is due, i.e. BT <= Current_BT.
- It interleaves the two queues in BT order and hands each event downstream over a valid/ready handshake.
- It signals completion when neither queue holds a due event.

Parameters:
NEURON_WIDTH, 11, width of neuron ID fields
BT_WIDTH, 36, biological-time width (32 integer + 4 fractional bits, unsigned)
COUNT_WIDTH, 16, width of per-timestep dispatched-event counter

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
ScheduleEnable  input  1  level; request to drain due events for current timestep
Current_BT  input  BT_WIDTH  current biological time; must be stable while ScheduleEnable=1
AuxIsQueueEmpty  input  1  Aux FIFO empty flag
AuxBT_Head  input  BT_WIDTH  BT of Aux FIFO head entry (combinational)
AuxBTOut  input  BT_WIDTH  Aux FIFO read-data BT
AuxNIDOut  input  NEURON_WIDTH  Aux FIFO read-data NID
AuxDequeue  output  1  one-cycle pop strobe to Aux FIFO
OutIsQueueEmpty  input  1  Out FIFO empty flag
OutBT_Head  input  BT_WIDTH  BT of Out FIFO head entry
OutBTOut  input  BT_WIDTH  Out FIFO read-data BT
OutNIDOut  input  NEURON_WIDTH  Out FIFO read-data NID
OutDequeue  output  1  one-cycle pop strobe to Out FIFO
EventValid  output  1  event presented downstream
EventReady  input  1  downstream accepts event
EventBT  output  BT_WIDTH  BT of presented event
EventNID  output  NEURON_WIDTH  NID of presented event
EventSource  output  1  0 = Aux, 1 = Out
EventCount  output  COUNT_WIDTH  events dispatched since last ScheduleEnable start
ScheduleComplete  output  1  one-cycle pulse when drain finished

Behaviour:
- Reset values: all outputs 0; the state register returns to IDLE; the tie-priority register TiePri is 0 (Aux first).
- FIFO contract:
  - BT_Head is valid whenever IsQueueEmpty=0.
  - A Dequeue sampled high at a rising edge makes BTOut/NIDOut valid from the next cycle.
- Eligibility and selection, evaluated in CHECK:
  - A queue is eligible when !IsQueueEmpty and BT_Head <= Current_BT. The compare is unsigned, full BT_WIDTH.
  - If both queues are eligible, the smaller BT_Head wins.
  - On equal BT_Head, the source named by TiePri wins, and TiePri is then toggled (tie round-robin).
- States:
  - IDLE: when ScheduleEnable=1, clear EventCount and go to CHECK.
  - CHECK: if ScheduleEnable=0, go to IDLE (no pulse). Else if any queue is eligible, register Sel and go to POP. Else go to DONE.
  - POP: assert the Dequeue of Sel only (registered output, high exactly this one cycle), then go to CAPTURE.
  - CAPTURE: latch the selected BTOut/NIDOut into EventBT/EventNID and set EventSource=Sel. Set EventValid=1 and go to OFFER.
  - OFFER: hold EventValid and the event data stable until EventReady=1. On the handshake cycle:
    - EventValid drops next cycle.
    - EventCount increments, saturating at all-ones.
    - Go to CHECK.
  - DONE: ScheduleComplete=1 for one cycle. Go to WAIT.
  - WAIT: hold until ScheduleEnable=0, then go to IDLE. This guarantees one pulse per request.
- Timing: minimum 4 cycles per event (CHECK, POP, CAPTURE, OFFER with EventReady already high).
- Exclusivity: AuxDequeue and OutDequeue are never high together.
- No dequeue is ever issued to an empty FIFO.
- ScheduleEnable dropped during POP/CAPTURE/OFFER:
  - The event in flight is still delivered; its handshake completes.
  - CHECK then returns to IDLE without asserting ScheduleComplete.
- Future-dated entries (BT > Current_BT) remain in their queue untouched.
- Reset asserted mid-operation forces IDLE immediately. The in-flight event is lost; the FIFO pop already issued is not undone.

Test Plan:
- Current_BT={32'd5,4'h0}; Aux holds BT 0x40/NID 8 and 0x50/NID 20; Out empty -> two events in order NID 8, NID 20. Exactly two AuxDequeue pulses, EventCount=2, then one ScheduleComplete pulse.
- Interleave: Aux heads 0x30, 0x48; Out heads 0x38, 0x50; Current_BT=0x50 -> EventSource sequence 0,1,0,1 with BT ascending.
- Tie: Aux and Out each hold BT 0x50 twice -> sources Aux, Out, Aux, Out (TiePri toggles).
- Future event: Aux head 0x58, Current_BT=0x50 -> no AuxDequeue; ScheduleComplete 3 cycles after ScheduleEnable rises (IDLE, CHECK, DONE); EventCount=0.
- Backpressure: EventReady held low 10 cycles -> EventValid, EventBT and EventNID stable throughout; no further Dequeue until the handshake.
- Abort/reset: drop ScheduleEnable during OFFER -> event completes, no ScheduleComplete. Assert Reset during POP -> all outputs 0 asynchronously; IDLE on release.
